// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first (acc = acc*10 + d).
// Optional macro BCD2BIN_SAT_EN: saturate bin_out to all-ones on overflow instead of wrapping.
module bcd_to_bin_seq #(
    parameter int NDIGITS = 5,
    parameter int WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd_in,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       bin_out,
    output logic                   ovf,
    output logic                   err
);

    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [4*NDIGITS-1:0]   digits;
    logic [WIDTH+3:0]       acc;
    logic [CW-1:0]          cnt;
    logic                   err_i;
    logic                   ovf_i;

    logic [3:0]             top_digit;
    logic [WIDTH+7:0]       acc_ext;
    logic [WIDTH+7:0]       acc_next;
    logic                   next_ovf;

    // acc_next is wide enough that any bit above WIDTH flags the overflow,
    // even after acc itself has wrapped.
    always_comb begin
        top_digit = digits[4*NDIGITS-1 -: 4];
        acc_ext   = {4'b0000, acc};
        acc_next  = (acc_ext << 3) + (acc_ext << 1) + {{(WIDTH+4){1'b0}}, top_digit};
        next_ovf  = |acc_next[WIDTH+7:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            digits  <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_i   <= 1'b0;
            ovf_i   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        digits <= bcd_in;
                        acc    <= '0;
                        cnt    <= CW'(NDIGITS - 1);
                        err_i  <= 1'b0;
                        ovf_i  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    acc    <= acc_next[WIDTH+3:0];
                    digits <= digits << 4;
                    if (top_digit > 4'd9) begin
                        err_i <= 1'b1;
                    end
                    if (next_ovf) begin
                        ovf_i <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (err_i) begin
                        bin_out <= '0;
                        err     <= 1'b1;
                        ovf     <= 1'b0;
                    end else if (ovf_i) begin
                        err <= 1'b0;
                        ovf <= 1'b1;
`ifdef BCD2BIN_SAT_EN
                        bin_out <= '1;
`else
                        bin_out <= acc[WIDTH-1:0];
`endif
                    end else begin
                        bin_out <= acc[WIDTH-1:0];
                        err     <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (NDIGITS=5, WIDTH=16).
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] bin_out;
    logic        ovf;
    logic        err;

    int passed;
    int total;

    bcd_to_bin_seq #(.NDIGITS(5), .WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .ovf     (ovf),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BCD2BIN_SAT_EN
    localparam logic [15:0] EXP_99999 = 16'hFFFF;
    localparam logic [15:0] EXP_65536 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_99999 = 16'h869F;
    localparam logic [15:0] EXP_65536 = 16'h0000;
`endif

    // Starts one conversion and waits for done; lat counts negedges from the
    // one following the accepting edge, busy_bad flags busy low before done.
    task automatic run_conv(input logic [19:0] v, output int lat, output bit busy_bad);
        busy_bad = 1'b0;
        start  = 1'b1;
        bcd_in = v;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            if (!busy) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_conv(input string name, input logic [19:0] v,
                              input logic [15:0] exp_bin, input logic exp_ovf, input logic exp_err);
        int lat;
        bit busy_bad;
        run_conv(v, lat, busy_bad);
        total++;
        if (lat !== 6) $display("FAIL %s latency: got %0d want 6", name, lat);
        else passed++;
        total++;
        if ({bin_out, ovf, err} !== {exp_bin, exp_ovf, exp_err})
            $display("FAIL %s result: got bin=%h ovf=%b err=%b want bin=%h ovf=%b err=%b",
                     name, bin_out, ovf, err, exp_bin, exp_ovf, exp_err);
        else passed++;
        total++;
        if (busy_bad || busy !== 1'b0)
            $display("FAIL %s busy: got busy_low_early=%b busy_at_done=%b want 0 0", name, busy_bad, busy);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({busy, done, bin_out, ovf, err} !== 20'h0)
            $display("FAIL reset_state: got busy=%b done=%b bin=%h ovf=%b err=%b want all 0",
                     busy, done, bin_out, ovf, err);
        else passed++;
    endtask

    task automatic test_basic();
        check_conv("conv_12345", 20'h12345, 16'h3039, 1'b0, 1'b0);
        total++;
        if (done !== 1'b0 || bin_out !== 16'h3039)
            $display("FAIL done_pulse_hold: got done=%b bin=%h want done=0 bin=3039", done, bin_out);
        else passed++;
    endtask

    task automatic test_boundary();
        check_conv("conv_65535", 20'h65535, 16'hFFFF, 1'b0, 1'b0);
        check_conv("conv_00000", 20'h00000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        check_conv("conv_99999", 20'h99999, EXP_99999, 1'b1, 1'b0);
        check_conv("conv_65536", 20'h65536, EXP_65536, 1'b1, 1'b0);
        check_conv("conv_after_ovf_777", 20'h00777, 16'h0309, 1'b0, 1'b0);
    endtask

    task automatic test_invalid();
        check_conv("conv_1A345", 20'h1A345, 16'h0000, 1'b0, 1'b1);
        check_conv("conv_FFFFF", 20'hFFFFF, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic test_busy_ignore();
        int ndone;
        start  = 1'b1;
        bcd_in = 20'h12345;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 20'h00042;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ndone++;
                total++;
                if (bin_out !== 16'h3039)
                    $display("FAIL ignore_start_result: got %h want 3039", bin_out);
                else passed++;
            end
            @(negedge clk);
        end
        total++;
        if (ndone !== 1) $display("FAIL ignore_start_count: got %0d done pulses want 1", ndone);
        else passed++;
        check_conv("conv_00042", 20'h00042, 16'h002A, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int ndone;
        start  = 1'b1;
        bcd_in = 20'h54321;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({busy, done, bin_out, ovf, err} !== 20'h0)
            $display("FAIL reset_mid_state: got busy=%b done=%b bin=%h ovf=%b err=%b want all 0",
                     busy, done, bin_out, ovf, err);
        else passed++;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        total++;
        if (ndone !== 0) $display("FAIL reset_mid_no_done: got %0d done pulses want 0", ndone);
        else passed++;
        check_conv("conv_after_reset", 20'h54321, 16'hD431, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int t;
        first  = -1;
        second = -1;
        start  = 1'b1;
        bcd_in = 20'h00100;
        for (t = 0; t < 30 && second < 0; t++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) first = t;
                else second = t;
                total++;
                if (bin_out !== 16'h0064)
                    $display("FAIL back_to_back_result: got %h want 0064", bin_out);
                else passed++;
            end
        end
        start = 1'b0;
        total++;
        if (first < 0 || second < 0 || (second - first) !== 7)
            $display("FAIL back_to_back_interval: got first=%0d second=%0d want interval 7", first, second);
        else passed++;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundary();
        test_overflow();
        test_invalid();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
